key_pulse_gen: RTL and testbench

- Input conditioning stage directly upstream of the per-player step tracker.
- Converts raw, bouncing, active-low push-button levels (one left and one right key per player) into clean single-cycle left/right pulses.
- Rejects same-cycle left+right collisions and gates pulses with the game enable, so the tracker sees at most one event per physical press.

---
 rtl/key_pulse_gen_pkg.sv | 24 ++
 rtl/key_pulse_gen_key_debounce.sv | 115 +++++++++++
 rtl/key_pulse_gen.sv | 93 +++++++++
 tb/tb_key_pulse_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the key input conditioning stage: button FSM
// state encoding and the default debounce window used by the top level
// and the benches.
package key_pulse_gen_pkg;

   // Button FSM states; the encoding is fixed so debug tools can decode it.
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } key_state_e;

   // 10 ms at 50 MHz.
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int CNT_W_DEF           = 19;

   // A button counts as held once a press has been accepted and until its
   // release has been confirmed.
   function automatic logic state_is_held(input key_state_e state);
      return (state == PRESSED) || (state == RELEASE_PEND);
   endfunction

endpackage

// File: rtl/key_pulse_gen_key_debounce.sv
// Single-button conditioner: two-flop synchronizer, stability counter and
// a four-state FSM. Emits a one-cycle accept strobe per debounced press
// and the debounced pressed level.
import key_pulse_gen_pkg::*;

module key_debounce #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_n,
   output logic accept,
   output logic held
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   // Last count of the stability window; the counter never goes past it.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             pressed_s;
   key_state_e       state_r;
   key_state_e       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             accept_r;
   logic             accept_nxt_s;
   logic             held_r;

   // Bring the asynchronous button level into the clk domain; idle is unpressed.
   always_ff @(posedge clk) begin
      if (resetn) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = ~sync2_r;

   // Next state, counter update and accept strobe for the debounce FSM.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      accept_nxt_s = 1'b0;
      case (state_r)
         RELEASED: begin
            if (pressed_s) begin
               cnt_nxt_s   = CNT_ONE;
               state_nxt_s = PRESS_PEND;
            end else begin
               state_nxt_s = RELEASED;
            end
         end
         PRESS_PEND: begin
            if (!pressed_s) begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = RELEASED;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s  = PRESSED;
               accept_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         PRESSED: begin
            // No auto-repeat: staying pressed produces nothing further.
            if (!pressed_s) begin
               cnt_nxt_s   = CNT_ONE;
               state_nxt_s = RELEASE_PEND;
            end else begin
               state_nxt_s = PRESSED;
            end
         end
         RELEASE_PEND: begin
            if (pressed_s) begin
               cnt_nxt_s   = CNT_ZERO;
               state_nxt_s = PRESSED;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = RELEASED;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = RELEASED;
         end
      endcase
   end

   // FSM state, counter and registered strobe/held outputs; reset drops any press in flight.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_r  <= RELEASED;
         cnt_r    <= CNT_ZERO;
         accept_r <= 1'b0;
         held_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         accept_r <= accept_nxt_s;
         held_r   <= state_is_held(state_nxt_s);
      end
   end

   assign accept = accept_r;
   assign held   = held_r;

endmodule

// File: rtl/key_pulse_gen.sv
// Per-player key conditioning: debounces the left and right buttons and
// turns accepted presses into single-cycle left/right pulses, reporting
// simultaneous presses as a collision and muting everything while the
// game is not running.
import key_pulse_gen_pkg::*;

module key_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,  // must be >= 2
   parameter int CNT_W           = CNT_W_DEF             // 2**CNT_W > DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic       key_left_n,
   input  logic       key_right_n,
   output logic       left,
   output logic       right,
   output logic       collide,
   output logic [1:0] held
);

   logic accept_left_s;
   logic accept_right_s;
   logic held_left_s;
   logic held_right_s;
   logic left_r;
   logic right_r;
   logic collide_r;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_left (
      .clk    (clk),
      .resetn (resetn),
      .key_n  (key_left_n),
      .accept (accept_left_s),
      .held   (held_left_s)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_right (
      .clk    (clk),
      .resetn (resetn),
      .key_n  (key_right_n),
      .accept (accept_right_s),
      .held   (held_right_s)
   );

   // Arbitrate accept strobes into exclusive pulses; while disabled the strobes are dropped.
   always_ff @(posedge clk) begin
      if (resetn) begin
         left_r    <= 1'b0;
         right_r   <= 1'b0;
         collide_r <= 1'b0;
      end else if (!enable) begin
         left_r    <= 1'b0;
         right_r   <= 1'b0;
         collide_r <= 1'b0;
      end else begin
         case ({accept_right_s, accept_left_s})
            2'b01: begin
               left_r    <= 1'b1;
               right_r   <= 1'b0;
               collide_r <= 1'b0;
            end
            2'b10: begin
               left_r    <= 1'b0;
               right_r   <= 1'b1;
               collide_r <= 1'b0;
            end
            2'b11: begin
               left_r    <= 1'b0;
               right_r   <= 1'b0;
               collide_r <= 1'b1;
            end
            default: begin
               left_r    <= 1'b0;
               right_r   <= 1'b0;
               collide_r <= 1'b0;
            end
         endcase
      end
   end

   assign left    = left_r;
   assign right   = right_r;
   assign collide = collide_r;
   assign held    = {held_right_s, held_left_s};

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen with a 4-cycle debounce window.
// Expected pulses (cycle and kind) are queued when a press is driven and
// matched against every pulse the DUT emits.
module tb_key_pulse_gen;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       key_left_n;
   logic       key_right_n;
   logic       left;
   logic       right;
   logic       collide;
   logic [1:0] held;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_err  = 0;
   int exp_q[$];

   // A press driven at the falling edge seen with cycle count c is first
   // sampled at the next rising edge; its pulse is visible at count c+7.
   localparam int PULSE_DELAY = 7;

   key_pulse_gen #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .key_left_n  (key_left_n),
      .key_right_n (key_right_n),
      .left        (left),
      .right       (right),
      .collide     (collide),
      .held        (held)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used to timestamp pulses.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Event code: cycle*8 + {collide, right, left}.
   function automatic int ev(input int c, input logic col, input logic r, input logic l);
      return c * 8 + (col ? 4 : 0) + (r ? 2 : 0) + (l ? 1 : 0);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every pulse the DUT emits must match the oldest queued expectation.
   always @(negedge clk) begin
      if (left || right || collide) begin
         if (exp_q.size() == 0)
            check("unexpected_pulse", ev(cyc, collide, right, left), -1);
         else
            check("pulse", ev(cyc, collide, right, left), exp_q.pop_front());
      end
   end

   initial begin
      resetn      = 1'b1;
      enable      = 1'b1;
      key_left_n  = 1'b1;
      key_right_n = 1'b1;
      tick(3);
      check("rst_left",    int'(left),    0);
      check("rst_right",   int'(right),   0);
      check("rst_collide", int'(collide), 0);
      check("rst_held",    int'(held),    0);
      resetn = 1'b0;
      tick(3);

      // Clean left press, then release timing of held.
      key_left_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b0, 1'b0, 1'b1));
      tick(10);
      check("clean_held", int'(held), 1);
      tick(10);
      key_left_n = 1'b1;
      tick(5);
      check("release_held_last", int'(held), 1);
      tick(1);
      check("release_held_drop", int'(held), 0);
      tick(5);

      // Bouncing right key: two short lows never complete the window.
      key_right_n = 1'b0;
      tick(2);
      key_right_n = 1'b1;
      tick(1);
      key_right_n = 1'b0;
      tick(2);
      key_right_n = 1'b1;
      tick(10);
      check("bounce_held", int'(held), 0);
      key_right_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b0, 1'b1, 1'b0));
      tick(10);
      key_right_n = 1'b1;
      tick(10);

      // Both keys in the same cycle.
      key_left_n  = 1'b0;
      key_right_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b1, 1'b0, 1'b0));
      tick(10);
      check("collide_held", int'(held), 3);
      key_left_n  = 1'b1;
      key_right_n = 1'b1;
      tick(10);

      // Left one cycle ahead of right.
      key_left_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b0, 1'b0, 1'b1));
      tick(1);
      key_right_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b0, 1'b1, 1'b0));
      tick(12);
      key_left_n  = 1'b1;
      key_right_n = 1'b1;
      tick(10);

      // Press accepted while disabled is not replayed when enable rises.
      enable     = 1'b0;
      key_left_n = 1'b0;
      tick(10);
      enable = 1'b1;
      tick(5);
      check("gated_held", int'(held), 1);
      key_left_n = 1'b1;
      tick(8);
      check("gated_released", int'(held), 0);
      key_left_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b0, 1'b0, 1'b1));
      tick(10);
      key_left_n = 1'b1;
      tick(10);

      // Reset while the left press is still pending abandons it.
      key_left_n = 1'b0;
      tick(3);
      resetn = 1'b1;
      tick(1);
      check("midrst_left",    int'(left),    0);
      check("midrst_right",   int'(right),   0);
      check("midrst_collide", int'(collide), 0);
      check("midrst_held",    int'(held),    0);
      resetn = 1'b0;
      tick(2);
      key_left_n = 1'b1;
      tick(10);
      key_left_n = 1'b0;
      exp_q.push_back(ev(cyc + PULSE_DELAY, 1'b0, 1'b0, 1'b1));
      tick(10);
      check("repress_held", int'(held), 1);
      key_left_n = 1'b1;
      tick(10);

      check("pending_pulses", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
